// File: rtl/river_lane_scheduler.sv
// river_lane_scheduler: per-lane step counters for the river lanes, frog carry
// displacement from the lane under the frog, and drown detection with a grace window.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | paused; counters frozen, outputs quiet, waiting for Enable
// RUN     | lanes counting, carry and drown evaluated every frame
// DROWNED | frog drowned; counters frozen until frog logic acks respawn
module river_lane_scheduler #(
  parameter int          N_LANES = 4,
  parameter logic [10:0] STEP    = 11'd20,
  parameter int          GRACE   = 2
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   Enable,
  input  logic [6*N_LANES-1:0]   Lane_Period,
  input  logic [N_LANES-1:0]     Lane_Dir,
  input  logic [N_LANES-1:0]     Pad_Collision,
  input  logic                   Frog_In_River,
  input  logic [2:0]             Frog_Lane,
  input  logic                   Respawn_Ack,
  output logic [N_LANES-1:0]     Lane_Step,
  output logic                   Carry_Valid,
  output logic [10:0]            Carry_Dx,
  output logic                   Drown,
  output logic [1:0]             State
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DROWNED = 2'b10
  } state_t;

  localparam logic [3:0] LANES_W  = 4'(N_LANES);
  localparam logic [3:0] GRACE_M1 = 4'(GRACE - 1);

  state_t             state_q;
  logic [5:0]         cnt_q [N_LANES];
  logic [3:0]         miss_q;
  logic [N_LANES-1:0] step_hit;
  logic               sel_cov;
  logic               sel_dir;
  logic               sel_step;
  logic               lane_ok;
  logic               uncovered;
  logic               carry_hit;

  // Terminal-count compare per lane: a hit means this edge produces a step.
  always_comb begin
    step_hit = '0;
    for (int i = 0; i < N_LANES; i++) begin
      step_hit[i] = (cnt_q[i] == Lane_Period[6*i +: 6]);
    end
  end

  // Pick out the lane under the frog; lanes past N_LANES never cover the frog.
  always_comb begin
    sel_cov  = 1'b0;
    sel_dir  = 1'b0;
    sel_step = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (Frog_Lane == 3'(i)) begin
        sel_cov  = Pad_Collision[i];
        sel_dir  = Lane_Dir[i];
        sel_step = step_hit[i];
      end
    end
    lane_ok   = ({1'b0, Frog_Lane} < LANES_W);
    uncovered = Frog_In_River & (~lane_ok | ~sel_cov);
    carry_hit = Frog_In_River & lane_ok & sel_cov & sel_step;
  end

  // Sequencer FSM with lane counters, miss counter and registered strobes.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < N_LANES; i++) cnt_q[i] <= 6'd0;
      miss_q      <= 4'd0;
      Lane_Step   <= '0;
      Carry_Valid <= 1'b0;
      Carry_Dx    <= 11'd0;
      Drown       <= 1'b0;
    end else begin
      Lane_Step   <= '0;
      Carry_Valid <= 1'b0;
      Carry_Dx    <= 11'd0;
      Drown       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Enable) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!Enable) begin
            state_q <= S_IDLE;
          end else begin
            for (int i = 0; i < N_LANES; i++) begin
              cnt_q[i] <= step_hit[i] ? 6'd0 : cnt_q[i] + 6'd1;
            end
            Lane_Step <= step_hit;
            if (carry_hit) begin
              Carry_Valid <= 1'b1;
              Carry_Dx    <= sel_dir ? STEP : (~STEP + 11'd1);
            end
            // Carry and drown are mutually exclusive: carry needs a covered frog.
            if (uncovered) begin
              if (miss_q == GRACE_M1) begin
                Drown   <= 1'b1;
                state_q <= S_DROWNED;
                miss_q  <= 4'd0;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end else begin
              miss_q <= 4'd0;
            end
          end
        end
        S_DROWNED: begin
          if (Respawn_Ack) state_q <= Enable ? S_RUN : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_river_lane_scheduler.sv
// Directed bench for river_lane_scheduler with a queue scoreboard of expected frames.
module tb_river_lane_scheduler;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_DROWNED = 2'b10;

  typedef struct {
    string      tag;
    logic [3:0] step;
    logic       cv;
    logic [10:0] dx;
    logic       drown;
    logic [1:0] state;
  } exp_t;

  logic        frame_clk;
  logic        Reset_n;
  logic        Enable;
  logic [23:0] Lane_Period;
  logic [3:0]  Lane_Dir;
  logic [3:0]  Pad_Collision;
  logic        Frog_In_River;
  logic [2:0]  Frog_Lane;
  logic        Respawn_Ack;
  logic [3:0]  Lane_Step;
  logic        Carry_Valid;
  logic [10:0] Carry_Dx;
  logic        Drown;
  logic [1:0]  State;

  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  int          per [4] = '{3, 0, 1, 63};
  logic [1:0]  exp_state = S_IDLE;
  exp_t        sb [$];

  river_lane_scheduler #(.N_LANES(4), .STEP(11'd20), .GRACE(2)) dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .Enable       (Enable),
    .Lane_Period  (Lane_Period),
    .Lane_Dir     (Lane_Dir),
    .Pad_Collision(Pad_Collision),
    .Frog_In_River(Frog_In_River),
    .Frog_Lane    (Frog_Lane),
    .Respawn_Ack  (Respawn_Ack),
    .Lane_Step    (Lane_Step),
    .Carry_Valid  (Carry_Valid),
    .Carry_Dx     (Carry_Dx),
    .Drown        (Drown),
    .State        (State)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected lane steps follow from the count of RUN frames since reset:
  // lane i steps on every (period+1)-th counted frame.
  task automatic tick(input string tag, input logic [1:0] nxt, input logic drn);
    exp_t e;
    exp_t got;
    logic counting;
    int   idx;
    counting = (exp_state == S_RUN) && Enable;
    if (counting) k++;
    e.tag = tag;
    e.step = '0;
    for (int i = 0; i < 4; i++) begin
      if (counting && (k % (per[i] + 1) == 0)) e.step[i] = 1'b1;
    end
    e.cv = 1'b0;
    e.dx = 11'd0;
    idx = int'(Frog_Lane);
    if (counting && Frog_In_River && idx < 4) begin
      if (Pad_Collision[idx] && e.step[idx]) begin
        e.cv = 1'b1;
        e.dx = Lane_Dir[idx] ? 11'd20 : 11'h7EC;
      end
    end
    e.drown = drn;
    e.state = nxt;
    sb.push_back(e);
    exp_state = nxt;
    @(posedge frame_clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".step"},  32'(Lane_Step),   32'(got.step));
    chk({got.tag, ".cv"},    32'(Carry_Valid), 32'(got.cv));
    chk({got.tag, ".dx"},    32'(Carry_Dx),    32'(got.dx));
    chk({got.tag, ".drown"}, 32'(Drown),       32'(got.drown));
    chk({got.tag, ".state"}, 32'(State),       32'(got.state));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".step"},  32'(Lane_Step),   32'd0);
    chk({tag, ".cv"},    32'(Carry_Valid), 32'd0);
    chk({tag, ".dx"},    32'(Carry_Dx),    32'd0);
    chk({tag, ".drown"}, 32'(Drown),       32'd0);
    chk({tag, ".state"}, 32'(State),       32'(S_IDLE));
  endtask

  initial begin
    Reset_n       = 1'b0;
    Enable        = 1'b0;
    Lane_Period   = {6'd63, 6'd1, 6'd0, 6'd3};
    Lane_Dir      = 4'b0000;
    Pad_Collision = 4'b0000;
    Frog_In_River = 1'b0;
    Frog_Lane     = 3'd0;
    Respawn_Ack   = 1'b0;
    #3;
    chk_quiet("reset");
    #7;
    Reset_n = 1'b1;

    tick("idle_hold", S_IDLE, 1'b0);
    Enable = 1'b1;
    tick("enter_run", S_RUN, 1'b0);
    for (int n = 0; n < 8; n++) tick("lane_count", S_RUN, 1'b0);

    Frog_In_River = 1'b1;
    Frog_Lane     = 3'd0;
    Pad_Collision = 4'b0001;
    for (int n = 0; n < 4; n++) tick("carry_left", S_RUN, 1'b0);
    Lane_Dir = 4'b0001;
    for (int n = 0; n < 4; n++) tick("carry_right", S_RUN, 1'b0);
    Frog_Lane     = 3'd1;
    Pad_Collision = 4'b0010;
    for (int n = 0; n < 2; n++) tick("carry_lane1", S_RUN, 1'b0);

    Frog_Lane     = 3'd0;
    Pad_Collision = 4'b0000;
    tick("miss_single", S_RUN, 1'b0);
    Pad_Collision = 4'b0001;
    tick("recover", S_RUN, 1'b0);
    Pad_Collision = 4'b0000;
    tick("miss_first", S_RUN, 1'b0);
    tick("drown", S_DROWNED, 1'b1);
    tick("drowned_hold", S_DROWNED, 1'b0);
    tick("drowned_hold2", S_DROWNED, 1'b0);

    Enable      = 1'b0;
    Respawn_Ack = 1'b1;
    tick("respawn_idle", S_IDLE, 1'b0);
    Respawn_Ack   = 1'b0;
    Frog_In_River = 1'b0;
    Enable        = 1'b1;
    tick("rerun", S_RUN, 1'b0);
    for (int n = 0; n < 4; n++) tick("resume_count", S_RUN, 1'b0);

    Enable = 1'b0;
    for (int n = 0; n < 10; n++) tick("paused", S_IDLE, 1'b0);
    Enable = 1'b1;
    tick("unpause", S_RUN, 1'b0);
    tick("unpause_1", S_RUN, 1'b0);
    tick("unpause_2", S_RUN, 1'b0);

    Frog_In_River = 1'b1;
    Frog_Lane     = 3'd5;
    Pad_Collision = 4'b1111;
    tick("oor_miss", S_RUN, 1'b0);
    tick("oor_drown", S_DROWNED, 1'b1);
    Frog_In_River = 1'b0;
    Respawn_Ack   = 1'b1;
    tick("respawn_run", S_RUN, 1'b0);
    Respawn_Ack   = 1'b0;

    Frog_In_River = 1'b1;
    Frog_Lane     = 3'd0;
    Pad_Collision = 4'b0000;
    tick("miss_again", S_RUN, 1'b0);
    tick("drown_again", S_DROWNED, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    k = 0;
    exp_state = S_IDLE;
    Frog_In_River = 1'b0;
    #1;
    Reset_n = 1'b1;
    tick("post_reset_run", S_RUN, 1'b0);
    tick("post_reset_cnt", S_RUN, 1'b0);
    tick("post_reset_cnt2", S_RUN, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
